// File: rtl/dcmi_frame_gen_if.sv
// DCMI camera-side bus: frame sync, line valid and pixel data.
interface dcmi_frame_gen_if #(
    parameter int unsigned DW = 8
);
    logic          CAM_VSYNC;
    logic          CAM_HREF;
    logic [DW-1:0] CAM_D;

    modport master (output CAM_VSYNC, output CAM_HREF, output CAM_D);
    modport slave  (input  CAM_VSYNC, input  CAM_HREF, input  CAM_D);
endinterface

// File: rtl/dcmi_frame_gen.sv
// DCMI timing and test-pattern source replacing a camera sensor.
// Configurable geometry, pattern modes, frame limit and run/stop control.
module dcmi_frame_gen #(
    parameter int unsigned DW       = 8,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_BLANK  = 10,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned VS_W     = 1,
    parameter int unsigned V_BACK   = 2,
    parameter int unsigned V_FRONT  = 2
) (
    input  logic              PCLK,
    input  logic              RESETn,
    input  logic              EN,
    input  logic [1:0]        MODE,
    input  logic [DW-1:0]     CONST_DATA,
    input  logic [15:0]       FRAME_LIMIT,
    dcmi_frame_gen_if.master  cam,
    output logic              BUSY,
    output logic              FRAME_DONE,
    output logic [15:0]       FRAME_CNT
);

    localparam int unsigned M1   = (H_ACTIVE > H_BLANK) ? H_ACTIVE : H_BLANK;
    localparam int unsigned M2   = (M1 > VS_W) ? M1 : VS_W;
    localparam int unsigned M3   = (M2 > V_BACK) ? M2 : V_BACK;
    localparam int unsigned MAXL = (M3 > V_FRONT) ? M3 : V_FRONT;
    localparam int unsigned CW   = $clog2(MAXL + 1);
    localparam int unsigned LW   = $clog2(V_ACTIVE + 1);

    localparam logic [CW-1:0] VS_LAST   = CW'(VS_W - 1);
    localparam logic [CW-1:0] VB_LAST   = CW'(V_BACK - 1);
    localparam logic [CW-1:0] HB_LAST   = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] HA_LAST   = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] VF_LAST   = CW'(V_FRONT - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(V_ACTIVE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_VSYNC, S_VBACK, S_HBLANK, S_ACTIVE, S_VFRONT
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] line_q, line_d;
    logic [31:0]   fcc_q, fcc_d;
    logic [1:0]    mode_q, mode_d;
    logic [DW-1:0] cdata_q, cdata_d;
    logic [15:0]   fcnt_q, fcnt_d;
    logic          limit_q, limit_d;
    logic          vsync_q, vsync_d;
    logic          href_q, href_d;
    logic [DW-1:0] d_q, d_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          enter_vs, enter_line, eof;
    logic [DW-1:0] pat;

    // Sequencing: per-state counter, zero-length states skipped, outputs from next state
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        line_d     = line_q;
        fcc_d      = fcc_q + 32'd1;
        mode_d     = mode_q;
        cdata_d    = cdata_q;
        fcnt_d     = fcnt_q;
        limit_d    = limit_q && EN;
        enter_vs   = 1'b0;
        enter_line = 1'b0;
        eof        = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                fcc_d = fcc_q;
                if (EN && !limit_q) begin
                    enter_vs = 1'b1;
                    fcnt_d   = '0;
                end
            end
            S_VSYNC: begin
                if (cnt_q == VS_LAST) begin
                    if (V_BACK != 0) begin
                        state_d = S_VBACK;
                        cnt_d   = '0;
                    end else begin
                        enter_line = 1'b1;
                        line_d     = '0;
                    end
                end
            end
            S_VBACK: begin
                if (cnt_q == VB_LAST) begin
                    enter_line = 1'b1;
                    line_d     = '0;
                end
            end
            S_HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    state_d = S_ACTIVE;
                    cnt_d   = '0;
                end
            end
            S_ACTIVE: begin
                if (cnt_q == HA_LAST) begin
                    if (line_q == LINE_LAST) begin
                        if (V_FRONT != 0) begin
                            state_d = S_VFRONT;
                            cnt_d   = '0;
                        end else begin
                            eof = 1'b1;
                        end
                    end else begin
                        enter_line = 1'b1;
                        line_d     = line_q + LW'(1);
                    end
                end
            end
            S_VFRONT: begin
                if (cnt_q == VF_LAST) eof = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // fcnt_q already counts the frame now ending
        if (eof) begin
            if (EN && (FRAME_LIMIT == 16'd0 || fcnt_q < FRAME_LIMIT)) begin
                enter_vs = 1'b1;
            end else begin
                state_d = S_IDLE;
                cnt_d   = '0;
                limit_d = EN;
            end
        end

        if (enter_vs) begin
            state_d = S_VSYNC;
            cnt_d   = '0;
            fcc_d   = '0;
            mode_d  = MODE;
            cdata_d = CONST_DATA;
        end
        if (enter_line) begin
            state_d = (H_BLANK != 0) ? S_HBLANK : S_ACTIVE;
            cnt_d   = '0;
        end

        done_d = (state_d == S_VFRONT && cnt_d == VF_LAST) ||
                 (V_FRONT == 0 && state_d == S_ACTIVE && cnt_d == HA_LAST &&
                  line_d == LINE_LAST);
        if (done_d && fcnt_q != 16'hFFFF) fcnt_d = fcnt_q + 16'd1;

        case (mode_d)
            2'd0:    pat = DW'(fcc_d);
            2'd1:    pat = DW'(cnt_d);
            2'd2:    pat = DW'(line_d);
            default: pat = cdata_d;
        endcase

        vsync_d = (state_d == S_VSYNC);
        href_d  = (state_d == S_ACTIVE);
        d_d     = href_d ? pat : '0;
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge PCLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            fcc_q   <= '0;
            mode_q  <= '0;
            cdata_q <= '0;
            fcnt_q  <= '0;
            limit_q <= 1'b0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            d_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            fcc_q   <= fcc_d;
            mode_q  <= mode_d;
            cdata_q <= cdata_d;
            fcnt_q  <= fcnt_d;
            limit_q <= limit_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign cam.CAM_VSYNC = vsync_q;
    assign cam.CAM_HREF  = href_q;
    assign cam.CAM_D     = d_q;
    assign BUSY          = busy_q;
    assign FRAME_DONE    = done_q;
    assign FRAME_CNT     = fcnt_q;

endmodule

// File: tb/tb_dcmi_frame_gen.sv
// Scoreboard bench: three instances (small, zero-blank edge, medium/DW=4) against a frame-position reference model.
module tb_dcmi_frame_gen;

    localparam int G_HA [3] = '{4, 4, 40};
    localparam int G_HB [3] = '{2, 0, 5};
    localparam int G_VA [3] = '{3, 3, 30};
    localparam int G_VS [3] = '{1, 1, 3};
    localparam int G_VB [3] = '{2, 0, 4};
    localparam int G_VF [3] = '{1, 0, 3};
    localparam int G_DW [3] = '{8, 8, 4};

    typedef struct packed {
        logic        vs;
        logic        href;
        logic [31:0] d;
        logic        busy;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n [3];
    logic        en    [3];
    logic [1:0]  mode  [3];
    logic [31:0] cdata [3];
    logic [15:0] lim   [3];
    logic        busy  [3];
    logic        done  [3];
    logic [15:0] fcnt  [3];
    logic        vs    [3];
    logic        href  [3];
    logic [31:0] dout  [3];
    logic        tb_end;

    always #5 clk = ~clk;

    dcmi_frame_gen_if #(.DW(8)) if0 ();
    dcmi_frame_gen_if #(.DW(8)) if1 ();
    dcmi_frame_gen_if #(.DW(4)) if2 ();

    dcmi_frame_gen #(.DW(8), .H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(3), .VS_W(1), .V_BACK(2), .V_FRONT(1)) u0 (
        .PCLK(clk), .RESETn(rst_n[0]), .EN(en[0]), .MODE(mode[0]), .CONST_DATA(cdata[0][7:0]),
        .FRAME_LIMIT(lim[0]), .cam(if0), .BUSY(busy[0]), .FRAME_DONE(done[0]), .FRAME_CNT(fcnt[0]));
    dcmi_frame_gen #(.DW(8), .H_ACTIVE(4), .H_BLANK(0), .V_ACTIVE(3), .VS_W(1), .V_BACK(0), .V_FRONT(0)) u1 (
        .PCLK(clk), .RESETn(rst_n[1]), .EN(en[1]), .MODE(mode[1]), .CONST_DATA(cdata[1][7:0]),
        .FRAME_LIMIT(lim[1]), .cam(if1), .BUSY(busy[1]), .FRAME_DONE(done[1]), .FRAME_CNT(fcnt[1]));
    dcmi_frame_gen #(.DW(4), .H_ACTIVE(40), .H_BLANK(5), .V_ACTIVE(30), .VS_W(3), .V_BACK(4), .V_FRONT(3)) u2 (
        .PCLK(clk), .RESETn(rst_n[2]), .EN(en[2]), .MODE(mode[2]), .CONST_DATA(cdata[2][3:0]),
        .FRAME_LIMIT(lim[2]), .cam(if2), .BUSY(busy[2]), .FRAME_DONE(done[2]), .FRAME_CNT(fcnt[2]));

    assign vs[0] = if0.CAM_VSYNC;  assign href[0] = if0.CAM_HREF;  assign dout[0] = 32'(if0.CAM_D);
    assign vs[1] = if1.CAM_VSYNC;  assign href[1] = if1.CAM_HREF;  assign dout[1] = 32'(if1.CAM_D);
    assign vs[2] = if2.CAM_VSYNC;  assign href[2] = if2.CAM_HREF;  assign dout[2] = 32'(if2.CAM_D);

    // Reference model: a frame is a flat position counter, outputs derived by arithmetic
    bit          m_run   [3];
    int          m_p     [3];
    int          m_cnt   [3];
    int          m_prev  [3];
    bit          m_latch [3];
    int          m_mode  [3];
    int unsigned m_cd    [3];
    int unsigned m_fcc   [3];
    exp_t        expq    [3][$];

    function automatic int flen(int k);
        return G_VS[k] + G_VB[k] + G_VA[k] * (G_HB[k] + G_HA[k]) + G_VF[k];
    endfunction

    task automatic start_frame(int k);
        m_run[k]  = 1'b1;
        m_p[k]    = 0;
        m_fcc[k]  = 0;
        m_mode[k] = int'(mode[k]);
        m_cd[k]   = cdata[k];
    endtask

    task automatic model_step(int k);
        if (!rst_n[k]) begin
            m_run[k] = 0; m_p[k] = 0; m_cnt[k] = 0; m_prev[k] = 0;
            m_latch[k] = 0; m_mode[k] = 0; m_cd[k] = 0; m_fcc[k] = 0;
            return;
        end
        if (!en[k]) m_latch[k] = 1'b0;
        if (!m_run[k]) begin
            if (en[k] && !m_latch[k]) begin
                start_frame(k);
                m_cnt[k] = 0;
            end
        end else if (m_p[k] == flen(k) - 1) begin
            if (en[k] && (lim[k] == 16'd0 || m_prev[k] + 1 < int'(lim[k]))) begin
                start_frame(k);
            end else begin
                m_run[k] = 1'b0;
                if (en[k]) m_latch[k] = 1'b1;
            end
        end else begin
            m_p[k]   = m_p[k] + 1;
            m_fcc[k] = m_fcc[k] + 1;
            if (m_p[k] == flen(k) - 1) begin
                m_prev[k] = m_cnt[k];
                m_cnt[k]  = (m_cnt[k] < 65535) ? m_cnt[k] + 1 : 65535;
            end
        end
    endtask

    function automatic exp_t model_out(int k);
        exp_t        e;
        int          ll, q, col, line;
        int unsigned mask;
        e    = '0;
        ll   = G_HB[k] + G_HA[k];
        mask = (32'd1 << G_DW[k]) - 32'd1;
        if (m_run[k]) begin
            e.busy = 1'b1;
            e.vs   = (m_p[k] < G_VS[k]);
            e.done = (m_p[k] == flen(k) - 1);
            q = m_p[k] - G_VS[k] - G_VB[k];
            if (q >= 0 && q < G_VA[k] * ll) begin
                line = q / ll;
                col  = q % ll;
                if (col >= G_HB[k]) begin
                    e.href = 1'b1;
                    case (m_mode[k])
                        0:       e.d = m_fcc[k] & mask;
                        1:       e.d = 32'(col - G_HB[k]) & mask;
                        2:       e.d = 32'(line) & mask;
                        default: e.d = m_cd[k] & mask;
                    endcase
                end
            end
        end
        e.cnt = 16'(m_cnt[k]);
        return e;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            model_step(k);
            expq[k].push_back(model_out(k));
        end
    end

    // Monitor: pops one expectation per instance per cycle, compares mid-cycle
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_done2 = 0, n_href2 = 0, n_vs2 = 0;

    always @(negedge clk) begin
        exp_t e, a;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            a = '{vs: vs[k], href: href[k], d: dout[k], busy: busy[k], done: done[k], cnt: fcnt[k]};
            total++;
            if (expq[k].size() == 0) begin
                bad++;
                $display("FAIL scoreboard_empty dut%0d cyc=%0d", k, cyc);
            end else begin
                e = expq[k].pop_front();
                if (!rst_n[k]) e = '0;
                if (a !== e) begin
                    bad++;
                    $display("FAIL outputs dut%0d cyc=%0d got vs=%0b href=%0b d=%0h busy=%0b done=%0b cnt=%0d want vs=%0b href=%0b d=%0h busy=%0b done=%0b cnt=%0d",
                             k, cyc, a.vs, a.href, a.d, a.busy, a.done, a.cnt,
                             e.vs, e.href, e.d, e.busy, e.done, e.cnt);
                end
            end
        end
        if (done[2]) n_done2++;
        if (href[2]) n_href2++;
        if (vs[2])   n_vs2++;

        if (tb_end) begin
            total++;
            if (n_done2 != 1) begin
                bad++; $display("FAIL dut2_frame_done_count got=%0d want=1", n_done2);
            end
            total++;
            if (n_href2 != 30 * 40) begin
                bad++; $display("FAIL dut2_href_cycles got=%0d want=%0d", n_href2, 30 * 40);
            end
            total++;
            if (n_vs2 != 3) begin
                bad++; $display("FAIL dut2_vsync_cycles got=%0d want=3", n_vs2);
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
        if (cyc > 5000) begin
            bad++;
            $display("FAIL watchdog cyc=%0d limit=5000", cyc);
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "watchdog expired");
        end
    end

    task automatic wait_c(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        tb_end = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; en[k] = 1'b0; mode[k] = 2'd0;
            cdata[k] = $urandom; lim[k] = 16'd0;
        end
        wait_c(3);
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;

        // Single-frame limit, latch holds IDLE until EN toggles
        en[0] = 1'b1; mode[0] = 2'd0; lim[0] = 16'd1;
        wait_c(30);
        en[0] = 1'b0; wait_c(1); en[0] = 1'b1;
        wait_c(30);

        // Ramps back-to-back, then a limit below the running count
        en[0] = 1'b0; wait_c(1);
        lim[0] = 16'd0; mode[0] = 2'd1; en[0] = 1'b1;
        wait_c(10); mode[0] = 2'd2;
        wait_c(60); lim[0] = 16'd2;
        wait_c(30);

        // Constant frame with mode flipped mid-frame
        en[0] = 1'b0; wait_c(1);
        lim[0] = 16'd0; mode[0] = 2'd3; cdata[0] = 32'h0000_00A5; en[0] = 1'b1;
        wait_c(8); mode[0] = 2'd1;
        wait_c(40); en[0] = 1'b0;
        wait_c(30);

        // Asynchronous reset during the first active line
        en[0] = 1'b1; mode[0] = 2'd0; cdata[0] = $urandom;
        wait_c(7);
        rst_n[0] = 1'b0; wait_c(2); rst_n[0] = 1'b1;
        wait_c(30); en[0] = 1'b0;
        wait_c(25);

        // Zero blanking geometry
        en[1] = 1'b1; mode[1] = 2'($urandom_range(0, 2)); lim[1] = 16'd2;
        wait_c(30); en[1] = 1'b0;
        wait_c(3);

        // EN drops during line 1 of a long frame; DW=4 truncates the ramp
        en[2] = 1'b1; mode[2] = 2'd1; lim[2] = 16'($urandom_range(0, 3));
        wait_c(62); en[2] = 1'b0;
        wait_c(1400);

        tb_end = 1'b1;
        wait_c(5);
    end

endmodule
